// File: rtl/bdpsk_pkg.sv
// Shared types and default constants for the BDPSK transmit controller.
package bdpsk_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_TAIL     = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // Default frame geometry.
  localparam int unsigned DEF_PRE_LEN  = 16;
  localparam logic [31:0] DEF_PRE_PAT  = 32'h0000_A5F0;
  localparam int unsigned DEF_PAY_LEN  = 64;
  localparam int unsigned DEF_TAIL_LEN = 4;
  localparam int unsigned DEF_GAP_LEN  = 8;

  // Largest of four phase lengths; sizes the shared phase counter.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bdpsk_phase_cnt.sv
// Loadable down-counter that stops at 1 and flags the terminal count.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes precedence over counting)
//   load_val   : value loaded on a phase entry
//   cnt        : registered count
//   term_c     : combinational flag, cnt == 1 (last cycle of the phase)
module bdpsk_phase_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         term_c
);

  // Count down, holding at 1 (or 0 when idle) so the value never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt > W'(1)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign term_c = (cnt == W'(1));

endmodule

// File: rtl/bdpsk_tx_ctrl.sv
// BDPSK transmit frame sequencer: INIT, preamble, payload, zero tail, guard gap.
// Ports:
//   clk_o, reset_n      : clock, async active-low reset
//   start, abort        : frame request (IDLE only) / immediate termination
//   src_valid, src_data : payload bit source; src_ready marks consumption
//   enc_clr/en/bit      : registered commands to the differential encoder
//   busy                : not IDLE (from state register)
//   frame_done          : pulse after the last tail (or payload) bit
//   underrun            : pulse when a zero filler replaces a missing payload bit
module bdpsk_tx_ctrl
  import bdpsk_pkg::*;
#(
  parameter int unsigned PRE_LEN  = DEF_PRE_LEN,
  parameter logic [31:0] PRE_PAT  = DEF_PRE_PAT,
  parameter int unsigned PAY_LEN  = DEF_PAY_LEN,
  parameter int unsigned TAIL_LEN = DEF_TAIL_LEN,
  parameter int unsigned GAP_LEN  = DEF_GAP_LEN
) (
  input  logic clk_o,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic src_valid,
  input  logic src_data,
  output logic src_ready,
  output logic enc_clr,
  output logic enc_en,
  output logic enc_bit,
  output logic busy,
  output logic frame_done,
  output logic underrun
);

  localparam int unsigned CNT_W = $clog2(max4(PRE_LEN, PAY_LEN, TAIL_LEN, GAP_LEN) + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, load_val;
  logic             load, term_c;
  logic [4:0]       pre_idx;
  logic             clr_n, en_n, bit_n, done_n, und_n;

  // Counter holds PRE_LEN at preamble bit 0, so bit index is cnt-1 (MSB first).
  assign pre_idx = 5'(cnt - CNT_W'(1));

  bdpsk_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk_o),
    .rst_n    (reset_n),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .term_c   (term_c)
  );

  // State register.
  always_ff @(posedge clk_o or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next state, counter load and next values of the registered outputs.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = '0;
    clr_n    = 1'b0;
    en_n     = 1'b0;
    bit_n    = 1'b0;
    done_n   = 1'b0;
    und_n    = 1'b0;

    if (abort && state != ST_IDLE) begin
      // Abort wins over everything and silences the encoder at the same edge.
      state_n = ST_IDLE;
      load    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_n  = ST_INIT;
            load     = 1'b1;
            load_val = CNT_W'(1);
          end
        end
        ST_INIT: begin
          clr_n    = 1'b1;
          state_n  = ST_PREAMBLE;
          load     = 1'b1;
          load_val = CNT_W'(PRE_LEN);
        end
        ST_PREAMBLE: begin
          en_n  = 1'b1;
          bit_n = PRE_PAT[pre_idx];
          if (term_c) begin
            state_n  = ST_PAYLOAD;
            load     = 1'b1;
            load_val = CNT_W'(PAY_LEN);
          end
        end
        ST_PAYLOAD: begin
          // Missing source bits become zero fillers; timing never stalls.
          en_n  = 1'b1;
          bit_n = src_valid & src_data;
          und_n = ~src_valid;
          if (term_c) begin
            load = 1'b1;
            if (TAIL_LEN == 0) begin
              state_n  = ST_GAP;
              load_val = CNT_W'(GAP_LEN);
            end else begin
              state_n  = ST_TAIL;
              load_val = CNT_W'(TAIL_LEN);
            end
          end
        end
        ST_TAIL: begin
          en_n = 1'b1;
          if (term_c) begin
            state_n  = ST_GAP;
            load     = 1'b1;
            load_val = CNT_W'(GAP_LEN);
          end
        end
        ST_GAP: begin
          // First gap cycle: the last data bit is on the encoder output now.
          done_n = (cnt == CNT_W'(GAP_LEN));
          if (term_c) begin
            state_n = ST_IDLE;
            load    = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          load    = 1'b1;
        end
      endcase
    end
  end

  // Encoder command and status registers, one cycle behind the state.
  always_ff @(posedge clk_o or negedge reset_n) begin
    if (!reset_n) begin
      enc_clr    <= 1'b0;
      enc_en     <= 1'b0;
      enc_bit    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      enc_clr    <= clr_n;
      enc_en     <= en_n;
      enc_bit    <= bit_n;
      frame_done <= done_n;
      underrun   <= und_n;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign src_ready = (state == ST_PAYLOAD);

endmodule

// File: tb/tb_bdpsk_tx_ctrl.sv
// Directed bench for bdpsk_tx_ctrl with PRE_LEN=4, PRE_PAT=1010, PAY_LEN=8,
// TAIL_LEN=2, GAP_LEN=3. Cycle 0 is the cycle in which start is sampled.
module tb_bdpsk_tx_ctrl;

  logic clk_o = 1'b0;
  logic reset_n, start, abort, src_valid, src_data;
  logic src_ready, enc_clr, enc_en, enc_bit, busy, frame_done, underrun;

  int passed = 0;
  int total  = 0;
  int zc;

  logic [31:0] din_pat = 32'hB38E_59C4;
  logic        pv = 1'b1;
  logic        pd = 1'b0;

  always #5 clk_o = ~clk_o;

  bdpsk_tx_ctrl #(
    .PRE_LEN  (4),
    .PRE_PAT  (32'h0000_000A),
    .PAY_LEN  (8),
    .TAIL_LEN (2),
    .GAP_LEN  (3)
  ) dut (
    .clk_o      (clk_o),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .enc_clr    (enc_clr),
    .enc_en     (enc_en),
    .enc_bit    (enc_bit),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // Expected {busy, src_ready, enc_clr, enc_en, enc_bit, frame_done, underrun}
  // at frame-relative cycle rel; pvl/pdl are the source bit offered the cycle before.
  function automatic logic [6:0] exp_vec(input int rel, input logic pvl, input logic pdl);
    logic b, r, c, e, d, f, u;
    b = (rel >= 1 && rel <= 18);
    r = (rel >= 6 && rel <= 13);
    c = (rel == 2);
    e = (rel >= 3 && rel <= 16);
    d = 1'b0;
    u = 1'b0;
    if (rel == 3 || rel == 5) d = 1'b1;
    if (rel >= 7 && rel <= 14) begin
      d = pvl & pdl;
      u = ~pvl;
    end
    f = (rel == 17);
    return {b, r, c, e, d, f, u};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {busy, src_ready, enc_clr, enc_en, enc_bit, frame_done, underrun};
  endfunction

  task automatic chk(input string tag, input int c, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: got %b want %b", tag, c, obs, exp);
  endtask

  // Drive one cycle's inputs, check outputs, advance to 1 unit after the next edge.
  task automatic cyc(input string tag, input int c, input int rel,
                     input logic st, input logic ab, input logic vl);
    start     = st;
    abort     = ab;
    src_valid = vl;
    src_data  = din_pat[5'(c)];
    chk(tag, c, obs_vec(), exp_vec(rel, pv, pd));
    pv = vl;
    pd = src_data;
    @(posedge clk_o);
    #1;
  endtask

  task automatic idle_tick();
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk_o);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    src_valid = 1'b0;
    src_data  = 1'b0;
    #2;
    chk("reset", 0, obs_vec(), 7'b0);
    @(posedge clk_o);
    #1;
    chk("reset_hold", 0, obs_vec(), 7'b0);
    reset_n = 1'b1;
    idle_tick();
    idle_tick();

    // Nominal frame.
    for (int c = 0; c <= 19; c++) cyc("nominal", c, c, c == 0, 1'b0, 1'b1);
    idle_tick();

    // Underrun: source not valid in cycles 9 and 10.
    for (int c = 0; c <= 19; c++)
      cyc("underrun", c, c, c == 0, 1'b0, !(c == 9 || c == 10));
    idle_tick();

    // Back-to-back frames with start held; second frame starts at cycle 19.
    zc = 0;
    for (int c = 0; c <= 37; c++) begin
      if (c >= 17 && c <= 21 && !enc_en && !enc_clr) zc++;
      cyc("b2b", c, (c < 19) ? c : c - 19, 1'b1, 1'b0, 1'b1);
    end
    cyc("b2b_end", 38, 19, 1'b0, 1'b0, 1'b1);
    chk("b2b_gap_zero", 38, 7'(zc), 7'd4);
    idle_tick();

    // Abort in cycle 8, new start in cycle 9.
    for (int c = 0; c <= 8; c++) cyc("abort", c, c, c == 0, c == 8, 1'b1);
    for (int c = 9; c <= 28; c++) cyc("abort_restart", c, c - 9, c == 9, 1'b0, 1'b1);
    idle_tick();

    // Start pulses during a frame are ignored.
    for (int c = 0; c <= 24; c++)
      cyc("ign_start", c, c, c == 0 || c == 4 || c == 17, 1'b0, 1'b1);
    idle_tick();

    // Reset in cycle 5 clears outputs without waiting for a clock edge.
    for (int c = 0; c <= 4; c++) cyc("midrst", c, c, c == 0, 1'b0, 1'b1);
    chk("midrst_pre", 5, obs_vec(), exp_vec(5, pv, pd));
    reset_n = 1'b0;
    #1;
    chk("midrst_async", 5, obs_vec(), 7'b0);
    @(posedge clk_o);
    #1;
    chk("midrst_hold", 6, obs_vec(), 7'b0);
    reset_n = 1'b1;
    idle_tick();
    for (int c = 0; c <= 19; c++) cyc("after_rst", c, c, c == 0, 1'b0, 1'b1);
    idle_tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
